// File: rtl/xpb_table_gen.sv
// Runtime-generated XPB reduction table: entry k = (k * base) mod modulus.
// One entry is produced per cycle by modular accumulation; NCH registered read ports serve lookups.
module xpb_table_gen #(
    parameter int WORD_W  = 1024,
    parameter int DIGIT_W = 5,
    parameter int NCH     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     gen_start,
    input  logic [WORD_W-1:0]        base,
    input  logic [WORD_W-1:0]        modulus,
    output logic                     gen_busy,
    output logic                     gen_done,
    output logic                     gen_err,
    output logic                     table_valid,
    input  logic [NCH-1:0]           rd_en,
    input  logic [NCH*DIGIT_W-1:0]   rd_idx,
    output logic [NCH*WORD_W-1:0]    rd_data,
    output logic [NCH-1:0]           rd_valid
);

    localparam int DEPTH = 2 ** DIGIT_W;
    localparam logic [DIGIT_W-1:0] LAST_K = {DIGIT_W{1'b1}};

    typedef enum logic {IDLE, GEN} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   base_q, base_d;
    logic [WORD_W-1:0]   mod_q, mod_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [DIGIT_W-1:0]  k_q, k_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                valid_q, valid_d;

    logic [WORD_W:0]     sum;
    logic [WORD_W-1:0]   next_entry;
    logic                start_ok;
    logic                wr_en;
    logic [DIGIT_W-1:0]  wr_addr;
    logic [WORD_W-1:0]   wr_data;

    logic [WORD_W-1:0]   table_mem [DEPTH];

    logic [NCH-1:0]        rd_valid_q, rd_valid_d;
    logic [NCH*WORD_W-1:0] rd_data_q, rd_data_d;

    // base_q < mod_q keeps acc + base below 2*M, so a single conditional subtract suffices.
    always_comb begin
        sum        = {1'b0, acc_q} + {1'b0, base_q};
        next_entry = (sum >= {1'b0, mod_q}) ? WORD_W'(sum - {1'b0, mod_q})
                                            : sum[WORD_W-1:0];
    end

    assign start_ok = gen_start && (modulus != '0) && (base < modulus);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        mod_d   = mod_q;
        acc_d   = acc_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        valid_d = valid_q;
        wr_en   = 1'b0;
        wr_addr = k_q;
        wr_data = next_entry;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    base_d  = base;
                    mod_d   = modulus;
                    acc_d   = '0;
                    k_d     = DIGIT_W'(1);
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    wr_data = '0;
                    state_d = GEN;
                end else if (gen_start) begin
                    err_d = 1'b1;
                end
            end
            GEN: begin
                wr_en = 1'b1;
                acc_d = next_entry;
                k_d   = k_q + DIGIT_W'(1);
                if (k_q == LAST_K) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    k_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            mod_q   <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            mod_q   <= mod_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    // Table storage is deliberately not reset; table_valid guards every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_valid_d = '0;
        rd_data_d  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (rd_en[c] && valid_q) begin
                rd_valid_d[c]                = 1'b1;
                rd_data_d[c*WORD_W +: WORD_W] = table_mem[rd_idx[c*DIGIT_W +: DIGIT_W]];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign gen_busy    = busy_q;
    assign gen_done    = done_q;
    assign gen_err     = err_q;
    assign table_valid = valid_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Self-checking bench for xpb_table_gen: generation timing, table contents against a
// multiply-and-modulo model, parallel reads, error path, async reset, abort and restart.
module tb_xpb_table_gen;

    localparam int W  = 1024;
    localparam int DW = 5;
    localparam int N  = 4;

    logic            clk;
    logic            reset;
    logic            gen_start;
    logic [W-1:0]    base_in;
    logic [W-1:0]    mod_in;
    logic            gen_busy;
    logic            gen_done;
    logic            gen_err;
    logic            table_valid;
    logic [N-1:0]    rd_en;
    logic [N*DW-1:0] rd_idx;
    logic [N*W-1:0]  rd_data;
    logic [N-1:0]    rd_valid;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
    } exp_t;

    exp_t         sb_q[$];
    int           checks;
    int           errors;
    logic         exp_valid;
    logic [W-1:0] exp_base;
    logic [W-1:0] exp_mod;

    xpb_table_gen #(.WORD_W(W), .DIGIT_W(DW), .NCH(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .gen_start   (gen_start),
        .base        (base_in),
        .modulus     (mod_in),
        .gen_busy    (gen_busy),
        .gen_done    (gen_done),
        .gen_err     (gen_err),
        .table_valid (table_valid),
        .rd_en       (rd_en),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference value computed as a full product followed by a true modulo.
    function automatic logic [W-1:0] model_entry(input int k, input logic [W-1:0] b,
                                                 input logic [W-1:0] m);
        logic [W+DW:0] p;
        logic [W+DW:0] mm;
        p        = '0;
        p[DW:0]  = k[DW:0];
        p        = p * {{(DW+1){1'b0}}, b};
        mm       = {{(DW+1){1'b0}}, m};
        return W'(p % mm);
    endfunction

    function automatic logic [N*DW-1:0] pack_idx(input int i0, input int i1,
                                                 input int i2, input int i3);
        return {DW'(i3), DW'(i2), DW'(i1), DW'(i0)};
    endfunction

    function automatic logic [N*W-1:0] pack4(input logic [W-1:0] d0, input logic [W-1:0] d1,
                                             input logic [W-1:0] d2, input logic [W-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [N*W-1:0] model_data(input logic [N*DW-1:0] idx);
        logic [N*W-1:0] r;
        for (int c = 0; c < N; c++) begin
            r[c*W +: W] = model_entry(int'(idx[c*DW +: DW]), exp_base, exp_mod);
        end
        return r;
    endfunction

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    // Drive one read cycle, push per-channel expectations, then pop and compare one cycle later.
    task automatic issue_read(input logic [N-1:0] en, input logic [N*DW-1:0] idx,
                              input logic [N*W-1:0] data);
        exp_t e;
        rd_en  = en;
        rd_idx = idx;
        for (int c = 0; c < N; c++) begin
            e.v = en[c] & exp_valid;
            e.d = e.v ? data[c*W +: W] : '0;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        rd_en = '0;
        for (int c = 0; c < N; c++) begin
            logic [W-1:0] got;
            e   = sb_q.pop_front();
            got = rd_data[c*W +: W];
            checks++;
            if (rd_valid[c] !== e.v) begin
                errors++;
                $display("[TB] FAIL rd_valid ch%0d idx %0d: got %b expected %b",
                         c, idx[c*DW +: DW], rd_valid[c], e.v);
            end
            checks++;
            if (got !== e.d) begin
                errors++;
                $display("[TB] FAIL rd_data ch%0d idx %0d: got hi=%h lo=%h expected hi=%h lo=%h",
                         c, idx[c*DW +: DW], got[W-1 -: 64], got[63:0], e.d[W-1 -: 64], e.d[63:0]);
            end
        end
    endtask

    task automatic read_all_model();
        logic [N*DW-1:0] idx;
        for (int k = 0; k < 32; k += N) begin
            idx = pack_idx(k, k + 1, k + 2, k + 3);
            issue_read({N{1'b1}}, idx, model_data(idx));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, " gen_busy"}, gen_busy, 1'b0);
        check_bit({tag, " gen_done"}, gen_done, 1'b0);
        check_bit({tag, " gen_err"}, gen_err, 1'b0);
        check_bit({tag, " table_valid"}, table_valid, 1'b0);
        checks++;
        if (rd_valid !== '0 || rd_data !== '0) begin
            errors++;
            $display("[TB] FAIL %s rd outputs: got rd_valid %b rd_data_lo %h expected 0",
                     tag, rd_valid, rd_data[63:0]);
        end
    endtask

    // Start a generation and follow it; optionally pulse gen_start mid-run or abort with reset.
    task automatic run_gen(input logic [W-1:0] b, input logic [W-1:0] m,
                           input logic inject, input int abort_at);
        int   cycles;
        logic done;
        gen_start = 1'b1;
        base_in   = b;
        mod_in    = m;
        @(posedge clk);
        #1;
        gen_start = 1'b0;
        exp_valid = 1'b0;
        cycles    = 0;
        done      = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (gen_done) begin
                done = 1'b1;
            end else begin
                if (gen_busy) cycles++;
                if (i == 0) check_bit("table_valid during gen", table_valid, 1'b0);
                if (inject && i == 5) begin
                    gen_start = 1'b1;
                    base_in   = W'(1);
                    mod_in    = W'(3);
                end else begin
                    gen_start = 1'b0;
                end
                if (abort_at != 0 && cycles == abort_at) begin
                    #2 reset = 1'b1;
                    #1 check_all_zero("abort");
                    #1 reset = 1'b0;
                    for (int j = 0; j < 3; j++) begin
                        @(posedge clk);
                        #1;
                        check_bit("table_valid after abort", table_valid, 1'b0);
                        check_bit("gen_busy after abort", gen_busy, 1'b0);
                    end
                    return;
                end
                @(posedge clk);
                #1;
            end
        end
        gen_start = 1'b0;
        check_bit("gen_done seen", done, 1'b1);
        checks++;
        if (cycles !== 31) begin
            errors++;
            $display("[TB] FAIL gen_busy cycles: got %0d expected 31", cycles);
        end
        check_bit("table_valid at done", table_valid, 1'b1);
        check_bit("gen_busy at done", gen_busy, 1'b0);
        @(posedge clk);
        #1;
        check_bit("gen_done single pulse", gen_done, 1'b0);
        exp_valid = 1'b1;
        exp_base  = b;
        exp_mod   = m;
    endtask

    task automatic bad_start(input logic [W-1:0] b, input logic [W-1:0] m);
        gen_start = 1'b1;
        base_in   = b;
        mod_in    = m;
        @(posedge clk);
        #1;
        gen_start = 1'b0;
        check_bit("gen_err pulse", gen_err, 1'b1);
        check_bit("gen_busy on error", gen_busy, 1'b0);
        check_bit("table_valid kept on error", table_valid, 1'b1);
        @(posedge clk);
        #1;
        check_bit("gen_err single pulse", gen_err, 1'b0);
        check_bit("gen_busy after error", gen_busy, 1'b0);
    endtask

    task automatic test_reset();
        #2 check_all_zero("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        issue_read({N{1'b1}}, pack_idx(0, 1, 2, 3), '0);
    endtask

    task automatic test_gen_1000();
        run_gen(W'(300), W'(1000), 1'b0, 0);
        issue_read({N{1'b1}}, pack_idx(0, 1, 3, 4),
                   pack4(W'(0), W'(300), W'(900), W'(200)));
        issue_read(4'b0011, pack_idx(10, 31, 0, 0), pack4(W'(0), W'(300), W'(0), W'(0)));
        read_all_model();
    endtask

    task automatic test_parallel();
        issue_read({N{1'b1}}, pack_idx(7, 7, 0, 31),
                   pack4(W'(100), W'(100), W'(0), W'(300)));
        issue_read(4'b0101, pack_idx(5, 6, 7, 8), pack4(W'(500), W'(0), W'(100), W'(0)));
    endtask

    task automatic test_error();
        bad_start(W'(1000), W'(1000));
        bad_start(W'(5), W'(0));
        read_all_model();
    endtask

    task automatic test_full_width();
        logic [W-1:0] big;
        logic [W-1:0] ones;
        big       = '0;
        big[W-1]  = 1'b1;
        ones      = '1;
        run_gen(big, ones, 1'b0, 0);
        issue_read({N{1'b1}}, pack_idx(2, 3, 0, 1), pack4(W'(1), big + W'(1), W'(0), big));
        read_all_model();
    endtask

    task automatic test_async_reset();
        rd_en  = {N{1'b1}};
        rd_idx = pack_idx(1, 2, 3, 4);
        @(posedge clk);
        #1;
        rd_en = '0;
        check_bit("rd_valid before reset", rd_valid[0], 1'b1);
        #2 reset = 1'b1;
        #1 check_all_zero("async reset");
        exp_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        issue_read({N{1'b1}}, pack_idx(1, 2, 3, 4), '0);
    endtask

    task automatic test_gen_ignore();
        run_gen(W'(300), W'(1000), 1'b1, 0);
        read_all_model();
    endtask

    task automatic test_abort_restart();
        run_gen(W'(300), W'(1000), 1'b0, 12);
        exp_valid = 1'b0;
        issue_read({N{1'b1}}, pack_idx(0, 1, 2, 3), '0);
        run_gen(W'(7), W'(11), 1'b0, 0);
        issue_read({N{1'b1}}, pack_idx(5, 31, 1, 0), pack4(W'(2), W'(8), W'(7), W'(0)));
        read_all_model();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_valid = 1'b0;
        exp_base  = '0;
        exp_mod   = W'(1);
        reset     = 1'b1;
        gen_start = 1'b0;
        base_in   = '0;
        mod_in    = '0;
        rd_en     = '0;
        rd_idx    = '0;

        test_reset();
        test_gen_1000();
        test_parallel();
        test_error();
        test_full_width();
        test_async_reset();
        test_gen_ignore();
        test_abort_restart();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
